// File: rtl/video_mem_arbiter.sv
// Single-port video memory arbiter: the scanner has absolute priority, and the two
// clients are served round-robin during blanking. Commands are registered, and read
// data returns to its issuer through a one-entry owner tag.
module video_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 9
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              display_active,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pulse,
  output logic [1:0]        dbg_state
);

  // Handshake: a client command transfers on a rising edge where reqN_valid and
  // reqN_ready are both high; the client holds its fields stable until then.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CLI0 = 2'd2,
    CLI1 = 2'd3
  } state_t;

  state_t            state_q, state_d;
  state_t            tag_own_q;
  logic              tag_vld_q;
  logic              last_gnt_q;
  logic              disp_act_q;
  logic              gnt0, gnt1;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    if (reset_reset) begin
      state_d = IDLE;
    end else if (disp_req) begin
      state_d = SCAN;
    end else if (!display_active) begin
      // last_gnt_q == 1 means client 1 was served last, so client 0 wins a tie
      if (req0_valid && (!req1_valid || last_gnt_q)) begin
        gnt0    = 1'b1;
        state_d = CLI0;
      end else if (req1_valid) begin
        gnt1    = 1'b1;
        state_d = CLI1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign dbg_state  = state_q;

  always_comb begin
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    case (state_d)
      SCAN: cmd_addr = disp_addr;
      CLI0: begin
        cmd_we    = req0_we;
        cmd_addr  = req0_addr;
        cmd_wdata = req0_wdata;
      end
      CLI1: begin
        cmd_we    = req1_we;
        cmd_addr  = req1_addr;
        cmd_wdata = req1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tag_vld_q   <= 1'b0;
      tag_own_q   <= IDLE;
      rdata       <= '0;
      disp_rvalid <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      disp_act_q  <= 1'b0;
      stall_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_en  <= (state_d != IDLE);
      mem_we  <= cmd_we;
      if (state_d != IDLE) begin
        mem_addr  <= cmd_addr;
        mem_wdata <= cmd_wdata;
      end
      if (gnt0) last_gnt_q <= 1'b0;
      else if (gnt1) last_gnt_q <= 1'b1;

      // Owner tag travels alongside the read command; the data comes back one cycle later
      tag_vld_q   <= (state_d != IDLE) && !cmd_we;
      tag_own_q   <= state_d;
      disp_rvalid <= tag_vld_q && (tag_own_q == SCAN);
      rsp0_valid  <= tag_vld_q && (tag_own_q == CLI0);
      rsp1_valid  <= tag_vld_q && (tag_own_q == CLI1);
      if (tag_vld_q) rdata <= mem_rdata;

      disp_act_q  <= display_active;
      stall_pulse <= display_active && !disp_act_q && (req0_valid || req1_valid);
    end
  end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed table-driven bench for video_mem_arbiter, plus a hand-written
// sequence that asserts reset while a read is in flight.
module tb_video_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 9;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic              display_active, disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic              req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              stall_pulse;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk_clk = ~clk_clk;

  // Memory model: read data is a fixed scramble of the address being commanded
  assign mem_rdata = mem_addr[8:0] ^ 9'h1B5;

  video_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .display_active(display_active),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_pulse(stall_pulse),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic       dr, da, v0, v1;
    logic       r0, r1;
    logic [1:0] st;
    logic       stall;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic dr, da, v0, v1, r0, r1,
                              input logic [1:0] st, input logic stall);
    vec_t v;
    v.dr = dr; v.da = da; v.v0 = v0; v.v1 = v1;
    v.r0 = r0; v.r1 = r1; v.st = st; v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " req0_ready"}, {31'd0, req0_ready}, 0);
    chk({tag, " req1_ready"}, {31'd0, req1_ready}, 0);
    chk({tag, " mem_en"}, {31'd0, mem_en}, 0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, " mem_addr"}, {20'd0, mem_addr}, 0);
    chk({tag, " mem_wdata"}, {23'd0, mem_wdata}, 0);
    chk({tag, " rdata"}, {23'd0, rdata}, 0);
    chk({tag, " disp_rvalid"}, {31'd0, disp_rvalid}, 0);
    chk({tag, " rsp0_valid"}, {31'd0, rsp0_valid}, 0);
    chk({tag, " rsp1_valid"}, {31'd0, rsp1_valid}, 0);
    chk({tag, " stall_pulse"}, {31'd0, stall_pulse}, 0);
    chk({tag, " state"}, {30'd0, dbg_state}, 0);
  endtask

  function automatic logic [ADDR_W-1:0] owner_addr(input logic [1:0] st);
    case (st)
      2'd1:    return 12'h300;
      2'd2:    return 12'h010;
      2'd3:    return 12'h020;
      default: return 12'h000;
    endcase
  endfunction

  initial begin
    logic             pend;
    logic [1:0]       pend_own;
    logic [DATA_W-1:0] pend_data;
    logic [ADDR_W-1:0] ea;

    // Fixed client and scanner fields: client 0 reads, client 1 writes
    disp_addr  = 12'h300;
    req0_addr  = 12'h010; req0_we = 1'b0; req0_wdata = 9'h055;
    req1_addr  = 12'h020; req1_we = 1'b1; req1_wdata = 9'h0C3;

    // Reset with a client valid: readies must stay low
    reset_reset = 1'b1; display_active = 1'b0; disp_req = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    step();
    step();
    check_reset_outputs("reset");

    //                dr    da    v0    v1    r0    r1    st    stall
    vecs[0]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    reset_reset = 1'b0;
    pend = 1'b0; pend_own = 2'd0; pend_data = '0;
    for (int i = 0; i < 13; i++) begin
      disp_req = vecs[i].dr; display_active = vecs[i].da;
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      #1;
      chk($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
      chk($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
      step();
      ea = owner_addr(vecs[i].st);
      chk($sformatf("v%0d state", i), {30'd0, dbg_state}, {30'd0, vecs[i].st});
      chk($sformatf("v%0d mem_en", i), {31'd0, mem_en}, {31'd0, (vecs[i].st != 2'd0)});
      if (vecs[i].st != 2'd0) begin
        chk($sformatf("v%0d mem_addr", i), {20'd0, mem_addr}, {20'd0, ea});
        chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, (vecs[i].st == 2'd3)});
      end
      if (vecs[i].st == 2'd3)
        chk($sformatf("v%0d mem_wdata", i), {23'd0, mem_wdata}, 32'h0C3);
      chk($sformatf("v%0d stall_pulse", i), {31'd0, stall_pulse}, {31'd0, vecs[i].stall});
      chk($sformatf("v%0d disp_rvalid", i), {31'd0, disp_rvalid}, {31'd0, (pend && pend_own == 2'd1)});
      chk($sformatf("v%0d rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, (pend && pend_own == 2'd2)});
      chk($sformatf("v%0d rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, (pend && pend_own == 2'd3)});
      if (pend)
        chk($sformatf("v%0d rdata", i), {23'd0, rdata}, {23'd0, pend_data});
      pend      = (vecs[i].st == 2'd1) || (vecs[i].st == 2'd2);
      pend_own  = vecs[i].st;
      pend_data = ea[8:0] ^ 9'h1B5;
    end

    // Reset lands in the mem_en cycle of a client 0 read: its response must vanish
    req0_valid = 1'b1; req1_valid = 1'b0; disp_req = 1'b0; display_active = 1'b0;
    #1;
    chk("rst_seq req0_ready", {31'd0, req0_ready}, 1);
    step();
    chk("rst_seq mem_en", {31'd0, mem_en}, 1);
    chk("rst_seq mem_addr", {20'd0, mem_addr}, 32'h010);
    reset_reset = 1'b1; req0_valid = 1'b0;
    step();
    check_reset_outputs("rst_seq after");
    reset_reset = 1'b0;
    step();
    chk("rst_seq late rsp0", {31'd0, rsp0_valid}, 0);
    chk("rst_seq late mem_en", {31'd0, mem_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_mem_arbiter.md
# video_mem_arbiter

Arbitrates the single-port video memory shared by the pixel scanner and two client ports: the sprite/instruction engine and the CPU bridge. The scanner has absolute priority and owns the memory during active video. The clients are served round-robin during blanking. Memory command outputs are registered, and read data is routed back to the issuing port through a one-entry owner tag pipeline. The block sits between the sync/timing generator, the colour-output scanner and the video memory.

## Interface
Parameters:
- ADDR_W, 12, video memory address width
- DATA_W, 9, memory word width (3-bit R, G, B)

Ports (clock and reset first):
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- display_active  in  1  high during active video region (from timing generator)
- disp_req  in  1  scanner read request (no ready; always accepted)
- disp_addr  in  ADDR_W  scanner read address
- disp_rvalid  out  1  scanner read data valid
- req0_valid / req1_valid  in  1  client request valid
- req0_ready / req1_ready  out  1  client request accepted (combinational)
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  client address
- req0_wdata / req1_wdata  in  DATA_W  client write data
- rsp0_valid / rsp1_valid  out  1  client read data valid
- rdata  out  DATA_W  shared read data bus (scanner and clients)
- mem_en, mem_we  out  1  memory command, registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read command
- stall_pulse  out  1  one cycle high when a client is blocked by display_active rising while its valid is high

## Operation
- Issue FSM states: IDLE (no command), SCAN (scanner owns the port), CLI0, CLI1. The state is the owner of the mem_* command registered this cycle.
- Arbitration each cycle, in priority order:
  - disp_req=1: go to SCAN, independent of display_active.
  - else display_active=1: go to IDLE; both readies stay 0.
  - else round-robin among valid clients. Priority goes to the client not granted last (register last_gnt). Grant to i: reqi_ready=1, go to CLIi, last_gnt←i.
  - else IDLE.
- At most one ready is high per cycle. Ready is never high while disp_req=1 or display_active=1.
- Accepted command: the next cycle drives mem_en=1, with mem_we/addr/wdata from the granted port. SCAN forces mem_we=0.
- Owner tag pipeline:
  - Reads capture the owner (SCAN, 0 or 1) into tag register T1.
  - The cycle after the memory command, rdata←mem_rdata (registered), and the matching valid pulses for 1 cycle.
  - Writes produce no response.
- stall_pulse: high for 1 cycle when display_active goes 0→1 (detected against its registered value) while req0_valid or req1_valid is high.

## Timing
- Reset values: all readies 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, disp_rvalid=0, rsp0_valid=0, rsp1_valid=0, stall_pulse=0, state IDLE, last_gnt=1 (req0 wins first tie).
- Read latency, request to valid: 2 cycles.
  - Request accepted at edge N.
  - mem_en high in cycle N+1.
  - Valid and rdata in cycle N+2.
  - Holds for scanner and clients.
- Throughput: one command per cycle; back-to-back grants allowed.
- display_active rising while a client is valid: ready drops that same cycle. A command already registered still executes and its response still returns.
- Simultaneous disp_req and client valid during blanking: scanner wins; the client waits and last_gnt is unchanged.
- Reset asserted mid-transaction: pipeline flushed next edge. In-flight responses are dropped (no valid pulse) and state returns to IDLE.
- Clients must hold valid, we, addr and wdata stable until ready. The block does not buffer unaccepted requests.

## Test plan
- Reset, then blanking (display_active=0), req0 read addr 0x010 with mem_rdata=0x1A5 → req0_ready high cycle 0, mem_en/addr 0x010 cycle 1, rsp0_valid=1 and rdata=0x1A5 cycle 2.
- Both clients valid continuously for 4 cycles of blanking → grants in order 0, 1, 0, 1, one mem_en per cycle.
- display_active=1 with disp_req each cycle and req1 write valid → req1_ready held 0 and stall_pulse once at the rise. After display_active falls, req1 is granted on the first cycle with disp_req=0 and mem_we=1 with its wdata.
- Blanking with disp_req and req0 valid in the same cycle → SCAN issued, disp_rvalid 2 cycles later. req0 is granted the next cycle and no rsp0 is attributed to the scanner read.
- req0 read accepted, then reset_reset asserted in the mem_en cycle → rsp0_valid never pulses and all outputs are at reset values after the edge.
